// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one dma_access channel among NREQ requesters, with a
// 2-deep owner tag FIFO routing each dma_end back to its issuer. Optional macro: DMA_ARB_BURST_EN.
module dma_arbiter #(
    parameter int NREQ    = 3,
    parameter int OWNW    = 2,
    parameter int BURSTLN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_in,
    input  logic [NREQ-1:0]      req_rnw,
    input  logic [NREQ*22-1:0]   req_addr,
    input  logic [NREQ*8-1:0]    req_wd,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_end,
    output logic [7:0]           req_rd,
    output logic                 dma_req,
    output logic                 dma_rnw,
    output logic [21:0]          dma_addr,
    output logic [7:0]           dma_wd,
    input  logic                 dma_ack,
    input  logic                 dma_end,
    input  logic [7:0]           dma_rd,
    output logic [OWNW-1:0]      owner,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [OWNW-1:0]   owner_q, owner_d;
    logic [OWNW-1:0]   last_q, last_d;
    logic [OWNW-1:0]   fifo_q [2];
    logic [OWNW-1:0]   fifo_d [2];
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              pick_valid;
    logic [OWNW-1:0]   pick_idx;
    logic              push;
    logic              pop;
    logic              end_hit;
    logic [OWNW-1:0]   end_tag;

`ifdef DMA_ARB_BURST_EN
    localparam int BW = $clog2(BURSTLN + 1);
    logic [BW-1:0]     burst_q, burst_d;
`else
    logic              unused_burstln;
    assign unused_burstln = (BURSTLN != 0);
`endif

    // Scan descending so the nearest requester after last_q is written last and wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_in[(int'(last_q) + k) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = OWNW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        req_ack  = '0;
        push     = 1'b0;
        dma_req  = 1'b0;
        dma_rnw  = 1'b0;
        dma_addr = '0;
        dma_wd   = '0;
`ifdef DMA_ARB_BURST_EN
        burst_d  = burst_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                dma_req  = req_in[owner_q] & (cnt_q != 2'd2);
                dma_rnw  = req_rnw[owner_q];
                dma_addr = req_addr[int'(owner_q)*22 +: 22];
                dma_wd   = req_wd[int'(owner_q)*8 +: 8];
                if (dma_req && dma_ack) begin
                    req_ack[owner_q] = 1'b1;
                    push             = 1'b1;
                    last_d           = owner_q;
                    state_d          = IDLE;
`ifdef DMA_ARB_BURST_EN
                    if (req_in[owner_q] && (burst_q < BW'(BURSTLN - 1))) begin
                        state_d = GRANT;
                        burst_d = burst_q + 1'b1;
                    end else begin
                        burst_d = '0;
                    end
`endif
                end else if (!req_in[owner_q]) begin
                    state_d = IDLE;
`ifdef DMA_ARB_BURST_EN
                    burst_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With an empty FIFO an end in the same cycle as an ack belongs to the owner being pushed.
    always_comb begin
        pop     = dma_end & (cnt_q != 2'd0);
        end_hit = dma_end & ((cnt_q != 2'd0) | push);
        end_tag = (cnt_q == 2'd0) ? owner_q : fifo_q[0];
        req_end = '0;
        if (end_hit) begin
            req_end[end_tag] = 1'b1;
        end
        req_rd  = end_hit ? dma_rd : 8'h00;
        fifo_d  = fifo_q;
        cnt_d   = cnt_q;
        if (push && dma_end) begin
            if (cnt_q != 2'd0) begin
                fifo_d[0] = owner_q;
            end
        end else if (push) begin
            fifo_d[cnt_q[0]] = owner_q;
            cnt_d            = cnt_q + 2'd1;
        end else if (pop) begin
            fifo_d[0] = fifo_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        err_d = err_q | (dma_end & ~end_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= OWNW'(NREQ - 1);
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

`ifdef DMA_ARB_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    assign owner = owner_q;
    assign busy  = (state_q == GRANT) | (cnt_q != 2'd0);
    assign err   = err_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Bench for dma_arbiter: directed transfers with an expected queue of ack/end pulses
// checked by a negedge monitor, plus direct checks of grant, stall and error behaviour.
module tb_dma_arbiter;

    localparam int NREQ = 3;
    localparam int OWNW = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_in;
    logic [NREQ-1:0]     req_rnw;
    logic [NREQ*22-1:0]  req_addr;
    logic [NREQ*8-1:0]   req_wd;
    logic [NREQ-1:0]     req_ack;
    logic [NREQ-1:0]     req_end;
    logic [7:0]          req_rd;
    logic                dma_req;
    logic                dma_rnw;
    logic [21:0]         dma_addr;
    logic [7:0]          dma_wd;
    logic                dma_ack;
    logic                dma_end;
    logic [7:0]          dma_rd;
    logic [OWNW-1:0]     owner;
    logic                busy;
    logic                err;

    logic [21:0]         addr_v [NREQ];
    logic [7:0]          wd_v [NREQ];

    logic [NREQ-1:0]     exp_ack_q [$];
    logic [NREQ+7:0]     exp_end_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    dma_arbiter #(.NREQ(NREQ), .OWNW(OWNW), .BURSTLN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_in(req_in), .req_rnw(req_rnw), .req_addr(req_addr), .req_wd(req_wd),
        .req_ack(req_ack), .req_end(req_end), .req_rd(req_rd),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_ack(dma_ack), .dma_end(dma_end), .dma_rd(dma_rd),
        .owner(owner), .busy(busy), .err(err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n   = 1'b0;
        req_in  = '0;
        dma_ack = 1'b0;
        dma_end = 1'b0;
        dma_rd  = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // driver tasks
    task automatic issue_ack(input int idx);
        int waited;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!dma_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!dma_req) begin
            chk("dma_req_wait", {31'd0, dma_req}, 32'd1);
            return;
        end
        tick();
        dma_ack = 1'b1;
        exp_ack_q.push_back(oh);
        @(negedge clk);
        chk("dma_addr", {10'd0, dma_addr}, {10'd0, addr_v[idx]});
        chk("dma_rnw", {31'd0, dma_rnw}, {31'd0, req_rnw[idx]});
        if (!req_rnw[idx]) chk("dma_wd", {24'd0, dma_wd}, {24'd0, wd_v[idx]});
        tick();
        dma_ack = 1'b0;
    endtask

    task automatic issue_end(input int idx, input logic [7:0] rd);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        tick();
        dma_end = 1'b1;
        dma_rd  = rd;
        exp_end_q.push_back({oh, rd});
        tick();
        dma_end = 1'b0;
        dma_rd  = 8'h00;
    endtask

    task automatic xfer(input int idx, input logic [7:0] rd);
        issue_ack(idx);
        issue_end(idx, rd);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ack != '0) begin
                if (exp_ack_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req_ack: got %b expected none at %0t", req_ack, $time);
                end else begin
                    chk("req_ack", {29'd0, req_ack}, {29'd0, exp_ack_q.pop_front()});
                end
            end
            if (req_end != '0) begin
                if (exp_end_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req_end: got %b/%h expected none at %0t", req_end, req_rd, $time);
                end else begin
                    chk("req_end_rd", {21'd0, req_end, req_rd}, {21'd0, exp_end_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int order [$];
        addr_v[0] = 22'h0ABCD; addr_v[1] = 22'h12345; addr_v[2] = 22'h3F00F;
        wd_v[0]   = 8'h11;     wd_v[1]   = 8'h22;     wd_v[2]   = 8'h33;
        req_addr  = {addr_v[2], addr_v[1], addr_v[0]};
        req_wd    = {wd_v[2], wd_v[1], wd_v[0]};
        req_rnw   = '0;
        req_in    = '0;
        dma_ack   = 1'b0;
        dma_end   = 1'b0;
        dma_rd    = 8'h00;
        rst_n     = 1'b0;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_dma_req", {31'd0, dma_req}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req_ack", {29'd0, req_ack}, 32'd0);
        chk("rst_req_end", {29'd0, req_end}, 32'd0);
        chk("rst_req_rd", {24'd0, req_rd}, 32'd0);
        chk("rst_dma_addr", {10'd0, dma_addr}, 32'd0);
        chk("rst_dma_wd", {24'd0, dma_wd}, 32'd0);
        chk("rst_dma_rnw", {31'd0, dma_rnw}, 32'd0);

        // single requester 1, read
        tick();
        req_in  = 3'b010;
        req_rnw = 3'b010;
        @(negedge clk);
        chk("arb_latency_req", {31'd0, dma_req}, 32'd0);
        @(negedge clk);
        chk("single_dma_req", {31'd0, dma_req}, 32'd1);
        chk("single_dma_addr", {10'd0, dma_addr}, 32'h12345);
        chk("single_owner", {30'd0, owner}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        xfer(1, 8'hA5);
        req_in = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("single_idle_busy", {31'd0, busy}, 32'd0);

        // round robin, all requesting
        do_reset();
        req_in  = 3'b111;
        req_rnw = 3'b101;
        for (int n = 0; n < 6; n++) xfer(n % 3, 8'h30 + 8'(n));
        req_in = '0;
        repeat (2) tick();

        // two outstanding stall, ignored ack, simultaneous ack and end
        do_reset();
        req_in  = 3'b011;
        req_rnw = 3'b000;
        issue_ack(0);
        issue_ack(1);
        repeat (2) tick();
        @(negedge clk);
        chk("stall_dma_req", {31'd0, dma_req}, 32'd0);
        chk("stall_owner", {30'd0, owner}, 32'd0);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        tick();
        dma_ack = 1'b1;
        @(negedge clk);
        chk("stall_ack_ignored", {29'd0, req_ack}, 32'd0);
        tick();
        dma_ack = 1'b0;
        issue_end(0, 8'h51);
        @(negedge clk);
        chk("resume_dma_req", {31'd0, dma_req}, 32'd1);
        tick();
        dma_ack = 1'b1;
        dma_end = 1'b1;
        dma_rd  = 8'h62;
        exp_ack_q.push_back(3'b001);
        exp_end_q.push_back({3'b010, 8'h62});
        tick();
        dma_ack = 1'b0;
        dma_end = 1'b0;
        dma_rd  = 8'h00;
        req_in  = '0;
        tick();
        @(negedge clk);
        chk("simul_busy_one_left", {31'd0, busy}, 32'd1);
        issue_end(0, 8'h73);
        @(negedge clk);
        chk("drained_busy", {31'd0, busy}, 32'd0);

        // stray end sets sticky err
        do_reset();
        tick();
        dma_end = 1'b1;
        dma_rd  = 8'h99;
        @(negedge clk);
        chk("stray_req_end", {29'd0, req_end}, 32'd0);
        chk("stray_req_rd", {24'd0, req_rd}, 32'd0);
        tick();
        dma_end = 1'b0;
        dma_rd  = 8'h00;
        @(negedge clk);
        chk("err_set", {31'd0, err}, 32'd1);
        repeat (5) tick();
        @(negedge clk);
        chk("err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("err_cleared", {31'd0, err}, 32'd0);

        // two requesters held: burst or alternate
`ifdef DMA_ARB_BURST_EN
        order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        order = '{0, 1, 0, 1};
`endif
        req_in  = 3'b011;
        req_rnw = 3'b001;
        foreach (order[i]) xfer(order[i], 8'h80 + 8'(i));
        req_in = '0;
        repeat (3) tick();

        chk("ack_queue_drained", exp_ack_q.size(), 32'd0);
        chk("end_queue_drained", exp_end_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
